// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and clear-FSM state type for the MIPS register file
package mips_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   // Register specifier that is hardwired to zero
   localparam int ZERO_REG = 0;

   typedef enum logic [0:0] {
      RF_CLEAR = 1'b0,
      RF_RUN   = 1'b1
   } rf_state_e;

endpackage

// File: rtl/rf_clear_fsm.sv
// rtl/rf_clear_fsm.sv - serial post-reset clear sequencer for the register array
module rf_clear_fsm
   import mips_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_idx_o,
   output logic                  ready_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

   rf_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;

   // Walk the index through every entry once, then hand over to RUN;
   // the index holds at the last entry so it never wraps.
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (state_q == RF_CLEAR) begin
         if (clr_idx_q == LAST_IDX) begin
            state_d = RF_RUN;
         end else begin
            clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
         end
      end
   end

   // Reset from any state (including mid-clear) restarts the full sequence
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= RF_CLEAR;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   assign clr_en_o  = (state_q == RF_CLEAR);
   assign clr_idx_o = clr_idx_q;
   assign ready_o   = (state_q == RF_RUN);

endmodule

// File: rtl/mips_register_file.sv
// rtl/mips_register_file.sv - 32x32 register file, 2 async reads, 1 sync write; REGFILE_DEBUG_PORT_EN adds a debug read port
module mips_register_file
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_REGS   = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] readReg1,
   input  logic [ADDR_WIDTH-1:0] readReg2,
   input  logic [ADDR_WIDTH-1:0] writeReg,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic                  regWrite,
`ifdef REGFILE_DEBUG_PORT_EN
   input  logic [ADDR_WIDTH-1:0] dbgReg,
   output logic [DATA_WIDTH-1:0] dbgData,
`endif
   output logic [DATA_WIDTH-1:0] readData1,
   output logic [DATA_WIDTH-1:0] readData2,
   output logic                  ready
);

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_idx;

   rf_clear_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_clear_fsm (
      .clk_i     (clk),
      .reset_i   (reset),
      .clr_en_o  (clr_en),
      .clr_idx_o (clr_idx),
      .ready_o   (ready)
   );

   // Single write port: the clear sequencer owns it in CLEAR, WB owns it in RUN
   always_ff @(posedge clk) begin
      if (clr_en) begin
         regs_q[clr_idx] <= '0;
      end else if (regWrite && (int'(writeReg) != ZERO_REG)) begin
         regs_q[writeReg] <= writeData;
      end
   end

   // Reads see the pre-edge value; forwarding of same-cycle writes happens downstream
   always_comb begin
      readData1 = '0;
      readData2 = '0;
      if (ready && (int'(readReg1) != ZERO_REG)) begin
         readData1 = regs_q[readReg1];
      end
      if (ready && (int'(readReg2) != ZERO_REG)) begin
         readData2 = regs_q[readReg2];
      end
   end

`ifdef REGFILE_DEBUG_PORT_EN
   // Debug read port follows the same zero rules as the main ports
   always_comb begin
      dbgData = '0;
      if (ready && (int'(dbgReg) != ZERO_REG)) begin
         dbgData = regs_q[dbgReg];
      end
   end
`endif

endmodule

// File: tb/tb_mips_register_file.sv
// tb/tb_mips_register_file.sv - directed self-checking bench for mips_register_file
module tb_mips_register_file;

   logic        clk;
   logic        reset;
   logic [4:0]  readReg1, readReg2, writeReg;
   logic [31:0] writeData;
   logic        regWrite;
   logic [31:0] readData1, readData2;
   logic        ready;
`ifdef REGFILE_DEBUG_PORT_EN
   logic [4:0]  dbgReg;
   logic [31:0] dbgData;
`endif

   int checks;
   int failures;
   int n;

   mips_register_file dut (
      .clk       (clk),
      .reset     (reset),
      .readReg1  (readReg1),
      .readReg2  (readReg2),
      .writeReg  (writeReg),
      .writeData (writeData),
      .regWrite  (regWrite),
`ifdef REGFILE_DEBUG_PORT_EN
      .dbgReg    (dbgReg),
      .dbgData   (dbgData),
`endif
      .readData1 (readData1),
      .readData2 (readData2),
      .ready     (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges until ready rises, bounded so a stuck FSM cannot hang the run
   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!ready && cnt < 40) begin
         tick();
         cnt++;
      end
   endtask

   task automatic write_reg(input logic [4:0] r, input logic [31:0] d);
      writeReg  = r;
      writeData = d;
      regWrite  = 1'b1;
      tick();
      regWrite  = 1'b0;
   endtask

   // Sets all read ports to one register and checks them all against exp
   task automatic read_all(input string tag, input logic [4:0] r, input logic [31:0] exp);
      readReg1 = r;
      readReg2 = r;
`ifdef REGFILE_DEBUG_PORT_EN
      dbgReg   = r;
`endif
      #1;
      check_eq({tag, "_rd1"}, readData1, exp);
      check_eq({tag, "_rd2"}, readData2, exp);
`ifdef REGFILE_DEBUG_PORT_EN
      check_eq({tag, "_dbg"}, dbgData, exp);
`endif
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset     = 1'b1;
      readReg1  = 5'd0;
      readReg2  = 5'd0;
      writeReg  = 5'd0;
      writeData = 32'h0;
      regWrite  = 1'b0;
`ifdef REGFILE_DEBUG_PORT_EN
      dbgReg    = 5'd0;
`endif

      // Initial reset and clear sequence
      tick();
      reset = 1'b0;
      check_eq("reset_ready", 32'(ready), 32'd0);
      read_all("reset_reads", 5'd7, 32'h0);
      wait_ready(n);
      check_eq("clear_cycles", 32'(n), 32'd32);
      check_eq("ready_after_clear", 32'(ready), 32'd1);
      for (int i = 1; i < 32; i++) read_all("cleared", 5'(i), 32'h0);

      // Basic write then read on both ports
      write_reg(5'd5, 32'hDEADBEEF);
      read_all("reg5", 5'd5, 32'hDEADBEEF);

      // Register 0 is never written
      write_reg(5'd0, 32'h12345678);
      read_all("reg0", 5'd0, 32'h0);

      // Same-cycle read of the written register returns the old value
      write_reg(5'd9, 32'h11);
      readReg2  = 5'd9;
      writeReg  = 5'd9;
      writeData = 32'h22;
      regWrite  = 1'b1;
      #1;
      check_eq("same_cycle_old", readData2, 32'h11);
      tick();
      regWrite = 1'b0;
      check_eq("same_cycle_new", readData2, 32'h22);

      // Reset mid-clear with WB write attempts to reg 3 throughout
      reset = 1'b1;
      tick();
      reset = 1'b0;
      read_all("clear_gated", 5'd5, 32'h0);
      writeReg  = 5'd3;
      writeData = 32'hFF;
      regWrite  = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check_eq("midclear_ready", 32'(ready), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_ready(n);
      regWrite = 1'b0;
      check_eq("midclear_cycles", 32'(n), 32'd32);
      read_all("reg3_after", 5'd3, 32'h0);
      read_all("reg9_after", 5'd9, 32'h0);

      // Reset in RUN: load every register, then pulse reset
      for (int i = 1; i < 32; i++) write_reg(5'(i), 32'hA5000000 | 32'(i));
      read_all("loaded17", 5'd17, 32'hA5000011);
      read_all("loaded31", 5'd31, 32'hA500001F);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("run_reset_ready", 32'(ready), 32'd0);
      read_all("run_reset_imm", 5'd17, 32'h0);
      wait_ready(n);
      check_eq("run_reset_cycles", 32'(n), 32'd32);
      for (int i = 1; i < 32; i++) read_all("run_cleared", 5'(i), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
